// File: rtl/board_led_shifter.sv
// Serialises WIDTH-bit LED frames into a 74HC595-style SIPO chain, LSB first,
// on a divided shift clock, then pulses the storage-register latch.
module board_led_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CLK_DIV = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             frame_done,
  output logic             ser_out,
  output logic             sr_clk_out,
  output logic             latch_out,
  output logic             oe_n_out
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
  localparam int unsigned BIT_W = $clog2(WIDTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, LATCH} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             div_last;

  // Shifted copy kept separate so WIDTH=1 never indexes past the register.
  assign shreg_next = shreg >> 1;
  assign div_last   = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shreg      <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      data_ready <= 1'b0;
      frame_done <= 1'b0;
      ser_out    <= 1'b0;
      sr_clk_out <= 1'b0;
      latch_out  <= 1'b0;
      oe_n_out   <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (data_valid && data_ready) begin
            shreg      <= data_in;
            ser_out    <= data_in[0];
            bit_cnt    <= '0;
            div_cnt    <= '0;
            data_ready <= 1'b0;
            state      <= LOW;
          end else begin
            data_ready <= 1'b1;
          end
        end
        LOW: begin
          if (div_last) begin
            div_cnt    <= '0;
            sr_clk_out <= 1'b1;
            state      <= HIGH;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        HIGH: begin
          if (div_last) begin
            div_cnt    <= '0;
            sr_clk_out <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              latch_out <= 1'b1;
              state     <= LATCH;
            end else begin
              // Next bit presented on the falling edge: full half-period setup and hold.
              shreg   <= shreg_next;
              ser_out <= shreg_next[0];
              bit_cnt <= bit_cnt + BIT_W'(1);
              state   <= LOW;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        LATCH: begin
          if (div_last) begin
            div_cnt    <= '0;
            latch_out  <= 1'b0;
            frame_done <= 1'b1;
            oe_n_out   <= 1'b0;
            data_ready <= 1'b1;
            state      <= IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_led_shifter.sv
// Self-checking bench: a 595 chain model watches the serial pins and its
// latched pattern is compared with the frames the bench offered.
module tb_board_led_shifter;

  localparam int W  = 32;
  localparam int CD = 4;
  localparam int LAT = W * 2 * CD + CD;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         data_valid = 1'b0;
  logic         data_ready, frame_done, ser_out, sr_clk_out, latch_out, oe_n_out;

  board_led_shifter #(.WIDTH(W), .CLK_DIV(CD)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .frame_done(frame_done), .ser_out(ser_out),
    .sr_clk_out(sr_clk_out), .latch_out(latch_out), .oe_n_out(oe_n_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 595 chain model plus pin-timing monitor.
  logic [W-1:0] chain = '0;
  logic [W-1:0] display = '0;
  int sr_rises = 0, latch_rises = 0, stab_viol = 0;
  int last_rise = -1000, last_ser_chg = -1000;
  logic prev_sr = 1'b0, prev_latch = 1'b0, prev_ser = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (sr_clk_out && !prev_sr) begin
        chain = {ser_out, chain[W-1:1]};
        sr_rises++;
        if (cyc - last_ser_chg < CD) stab_viol++;
        last_rise = cyc;
      end
      if (ser_out !== prev_ser) begin
        if (cyc - last_rise < CD) stab_viol++;
        last_ser_chg = cyc;
      end
      if (latch_out && !prev_latch) begin
        display = chain;
        latch_rises++;
      end
    end else begin
      last_rise = -1000;
    end
    prev_sr    = sr_clk_out;
    prev_latch = latch_out;
    prev_ser   = ser_out;
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] v, output int acc);
    bit ok = 0;
    acc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (data_ready) begin ok = 1; break; end
    end
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
    data_in = v;
    data_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    bit ok = 0;
    dcyc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (frame_done) begin ok = 1; dcyc = cyc; break; end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Outputs packed as {data_ready, frame_done, ser, sr_clk, latch, oe_n}.
  function automatic logic [31:0] pins();
    return {26'd0, data_ready, frame_done, ser_out, sr_clk_out, latch_out, oe_n_out};
  endfunction

  initial begin
    int acc, acc2, dcyc, sr0, la0;
    logic [W-1:0] v;

    // Reset
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pins", pins(), 32'h01);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", {31'd0, data_ready}, 32'd1);

    // Single frame
    sr0 = sr_rises; la0 = latch_rises;
    send(32'hA5A5_0001, acc);
    wait_done(dcyc);
    chk("latency", dcyc - acc, LAT);
    chk("oe_n_at_done", {31'd0, oe_n_out}, 32'd0);
    chk("ready_at_done", {31'd0, data_ready}, 32'd1);
    chk("display_a5a5", display, 32'hA5A5_0001);
    chk("sr_rise_count", sr_rises - sr0, W);
    chk("latch_rise_count", latch_rises - la0, 1);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, frame_done}, 32'd0);

    // Bit order
    send(32'h0000_0001, acc);
    wait_done(dcyc);
    chk("display_bit0", display, 32'h0000_0001);
    chk("ser_stability", stab_viol, 0);

    // Busy ignore
    sr0 = sr_rises;
    send(32'h0000_FFFF, acc);
    while (cyc < acc + 50) @(negedge clk);
    data_in = 32'hFFFF_0000; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    wait_done(dcyc);
    chk("busy_display", display, 32'h0000_FFFF);
    repeat (20) @(negedge clk);
    chk("busy_no_second_frame", sr_rises - sr0, W);
    send(32'hFFFF_0000, acc);
    wait_done(dcyc);
    chk("busy_resend", display, 32'hFFFF_0000);

    // Reset mid-frame during bit 10
    sr0 = sr_rises; la0 = latch_rises;
    send(32'hDEAD_BEEF, acc);
    for (int i = 0; i < 2000 && (sr_rises - sr0) < 10; i++) @(negedge clk);
    chk("reached_bit10", sr_rises - sr0, 10);
    #2 reset_n = 1'b0;
    #1 chk("midreset_pins", pins(), 32'h01);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midreset_no_latch", latch_rises - la0, 0);
    chk("midreset_display", display, 32'hFFFF_0000);
    chk("midreset_oe_n", {31'd0, oe_n_out}, 32'd1);
    send(32'h1234_5678, acc);
    wait_done(dcyc);
    chk("after_reset_frame", display, 32'h1234_5678);
    chk("after_reset_oe_n", {31'd0, oe_n_out}, 32'd0);

    // Back-to-back with data_valid held high
    acc = -1; acc2 = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (data_ready) break;
    end
    data_in = 32'h0F0F_0F0F; data_valid = 1'b1;
    @(posedge clk); #1; acc = cyc;
    @(negedge clk);
    data_in = 32'hF0F0_F0F0;
    wait_done(dcyc);
    chk("b2b_first", display, 32'h0F0F_0F0F);
    @(posedge clk); #1; acc2 = cyc;
    chk("b2b_second_accepted", {31'd0, data_ready}, 32'd0);
    @(negedge clk);
    data_valid = 1'b0;
    chk("b2b_spacing", acc2 - acc, LAT + 1);
    wait_done(dcyc);
    chk("b2b_second", display, 32'hF0F0_F0F0);

    // Random frames with random idle gaps
    for (int k = 0; k < 4; k++) begin
      v = $urandom;
      repeat ($urandom_range(0, 7)) @(negedge clk);
      la0 = latch_rises;
      send(v, acc);
      wait_done(dcyc);
      chk("rand_display", display, v);
      chk("rand_latency", dcyc - acc, LAT);
      chk("rand_latch_count", latch_rises - la0, 1);
    end
    chk("ser_stability_final", stab_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
